// File: rtl/prog_loader.sv
// Host byte-stream loader: frames SYNC/LEN/payload into program-memory writes and holds the uP in reset until done.
// Optional running-sum check of the payload is enabled with the PROG_LOADER_CHECKSUM_EN macro.
module prog_loader #(
  parameter int          ADDR_WIDTH = 10,
  parameter int          INSN_WIDTH = 16,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [7:0]            iByteData,
  input  logic                  iByteValid,
  output logic                  oByteReady,
  output logic                  oMemWrEn,
  output logic [ADDR_WIDTH-1:0] oMemAddr,
  output logic [INSN_WIDTH-1:0] oMemData,
  output logic                  oCpuReset,
  output logic                  oDone,
  output logic                  oError
);

  localparam int BPW = INSN_WIDTH / 8;
  localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DATA   = 3'd3,
`ifdef PROG_LOADER_CHECKSUM_EN
    S_CHK    = 3'd4,
`endif
    S_DONE   = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

  state_t                state_q, state_d;
  logic [15:0]           len_q, len_d;
  logic [INSN_WIDTH-1:0] word_q, word_d;
  logic [BCW-1:0]        byte_cnt_q, byte_cnt_d;
  logic [ADDR_WIDTH-1:0] word_idx_q, word_idx_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [INSN_WIDTH-1:0] data_q, data_d;
  logic                  done_q, done_d;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]            sum_q, sum_d;
  logic [7:0]            chk_total;
`endif

  logic                  ready_state;
  logic                  accept;
  logic [15:0]           len_full;
  logic [INSN_WIDTH-1:0] assembled;
  logic                  last_word;

  always_comb begin
    ready_state = 1'b0;
    case (state_q)
      S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA: ready_state = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
      S_CHK:                              ready_state = 1'b1;
`endif
      default:                            ready_state = 1'b0;
    endcase
  end

  assign oByteReady = ready_state && !Reset;
  assign accept     = iByteValid && oByteReady;
  assign len_full   = {len_q[15:8], iByteData};
  assign assembled  = INSN_WIDTH'({word_q, iByteData});
  assign last_word  = (17'(word_idx_q) == (17'(len_q) - 17'd1));
`ifdef PROG_LOADER_CHECKSUM_EN
  assign chk_total  = sum_q + iByteData;
`endif

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_d     = word_q;
    byte_cnt_d = byte_cnt_q;
    word_idx_d = word_idx_q;
    wr_en_d    = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    done_d     = done_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    sum_d      = sum_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (accept && (iByteData == SYNC_BYTE)) state_d = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (accept) begin
          len_d[15:8] = iByteData;
          state_d     = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          len_d      = len_full;
          byte_cnt_d = '0;
          word_idx_d = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
          sum_d      = '0;
`endif
          // Bounding N here is what makes address wrap impossible in DATA
          if ((len_full == 16'd0) || ({1'b0, len_full} > MAX_WORDS)) state_d = S_ERROR;
          else                                                      state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          word_d = assembled;
`ifdef PROG_LOADER_CHECKSUM_EN
          sum_d  = sum_q + iByteData;
`endif
          if (byte_cnt_q == BCW'(BPW - 1)) begin
            wr_en_d    = 1'b1;
            addr_d     = word_idx_q;
            data_d     = assembled;
            byte_cnt_d = '0;
            word_idx_d = word_idx_q + ADDR_WIDTH'(1);
            if (last_word) begin
`ifdef PROG_LOADER_CHECKSUM_EN
              state_d = S_CHK;
`else
              state_d = S_DONE;
`endif
            end
          end else begin
            byte_cnt_d = byte_cnt_q + BCW'(1);
          end
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (accept) begin
          if (chk_total == 8'h00) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_ERROR;
          end
        end
      end
`endif
      // Done is raised one cycle after entry so it trails the final write pulse
      S_DONE:  done_d = 1'b1;
      S_ERROR: done_d = 1'b0;
      default: state_d = S_ERROR;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      word_q     <= '0;
      byte_cnt_q <= '0;
      word_idx_q <= '0;
      wr_en_q    <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      done_q     <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_q     <= word_d;
      byte_cnt_q <= byte_cnt_d;
      word_idx_q <= word_idx_d;
      wr_en_q    <= wr_en_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      done_q     <= done_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

  assign oMemWrEn  = wr_en_q;
  assign oMemAddr  = addr_q;
  assign oMemData  = data_q;
  assign oDone     = done_q;
  assign oCpuReset = !done_q;
  assign oError    = (state_q == S_ERROR);

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: stimulus pushes expected writes, a negedge monitor pops and compares.
module tb_prog_loader;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [7:0]  iByteData = 8'h00;
  logic        iByteValid = 1'b0;
  logic        oByteReady, oMemWrEn, oCpuReset, oDone, oError;
  logic [9:0]  oMemAddr;
  logic [15:0] oMemData;

  prog_loader #(.ADDR_WIDTH(10), .INSN_WIDTH(16), .SYNC_BYTE(8'hA5)) dut (
    .Clock(Clock), .Reset(Reset), .iByteData(iByteData), .iByteValid(iByteValid),
    .oByteReady(oByteReady), .oMemWrEn(oMemWrEn), .oMemAddr(oMemAddr), .oMemData(oMemData),
    .oCpuReset(oCpuReset), .oDone(oDone), .oError(oError)
  );

  always #5 Clock = ~Clock;

  typedef struct packed { logic [9:0] addr; logic [15:0] data; } wr_t;
  wr_t exp_q[$];
  int  tests = 0;
  int  fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge Clock);
      if (oMemWrEn === 1'b1) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: addr %0h data %0h with no write expected", oMemAddr, oMemData);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_addr", 32'(oMemAddr), 32'(e.addr));
          check("wr_data", 32'(oMemData), 32'(e.data));
        end
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    bit r;
    iByteData  = b;
    iByteValid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clock);
      r = oByteReady;
      @(posedge Clock);
      #1;
      if (r) begin
        iByteValid = 1'b0;
        return;
      end
    end
    iByteValid = 1'b0;
    tests++;
    fails++;
    $display("FAIL byte_accept_timeout: byte %0h not accepted, required accept within 20 cycles", b);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    #1;
    check("ready_in_reset", 32'(oByteReady), 32'd0);
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    check("rst_wren", 32'(oMemWrEn), 32'd0);
    check("rst_addr", 32'(oMemAddr), 32'd0);
    check("rst_data", 32'(oMemData), 32'd0);
    check("rst_cpureset", 32'(oCpuReset), 32'd1);
    check("rst_done", 32'(oDone), 32'd0);
    check("rst_error", 32'(oError), 32'd0);
  endtask

  // Sends a complete frame and queues the expected writes; adds the checksum byte when enabled.
  task automatic send_words(input logic [15:0] ws[$]);
    logic [7:0] sum;
    sum = 8'h00;
    for (int i = 0; i < ws.size(); i++) exp_q.push_back({10'(i), ws[i]});
    send_byte(8'hA5);
    send_byte(8'(ws.size() >> 8));
    send_byte(8'(ws.size()));
    foreach (ws[i]) begin
      send_byte(ws[i][15:8]);
      send_byte(ws[i][7:0]);
      sum = sum + ws[i][15:8] + ws[i][7:0];
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(8'h00 - sum);
`endif
  endtask

  task automatic expect_done();
`ifdef PROG_LOADER_CHECKSUM_EN
    check("done_after_chk", 32'(oDone), 32'd1);
    check("cpureset_after_chk", 32'(oCpuReset), 32'd0);
`else
    check("last_wr_at_k1", 32'(oMemWrEn), 32'd1);
    check("done_at_k1", 32'(oDone), 32'd0);
    check("cpureset_at_k1", 32'(oCpuReset), 32'd1);
    @(posedge Clock);
    #1;
    check("done_at_k2", 32'(oDone), 32'd1);
    check("cpureset_at_k2", 32'(oCpuReset), 32'd0);
`endif
    check("ready_in_done", 32'(oByteReady), 32'd0);
    check("error_in_done", 32'(oError), 32'd0);
  endtask

  task automatic expect_error();
    check("error_flag", 32'(oError), 32'd1);
    check("ready_in_error", 32'(oByteReady), 32'd0);
    check("cpureset_in_error", 32'(oCpuReset), 32'd1);
    check("done_in_error", 32'(oDone), 32'd0);
    idle_cycles(3);
    check("error_sticky", 32'(oError), 32'd1);
  endtask

  initial begin
    logic [15:0] ws[$];
    @(posedge Clock);
    #1;
    do_reset();

    // Two-word frame, back-to-back bytes
    ws = '{16'h1234, 16'hABCD};
    send_words(ws);
    expect_done();
    iByteData  = 8'hA5;
    iByteValid = 1'b1;
    idle_cycles(4);
    iByteValid = 1'b0;
    check("done_ignores_bytes", 32'(oDone), 32'd1);
    check("q_after_frame1", 32'(exp_q.size()), 32'd0);

    // Leading junk discarded, idle gap mid-word
    do_reset();
    exp_q.push_back({10'h000, 16'hBEEF});
    send_byte(8'h00);
    send_byte(8'hFF);
    check("junk_stays_idle", 32'(oByteReady), 32'd1);
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'hBE);
    idle_cycles(3);
    check("gap_no_done", 32'(oDone), 32'd0);
    send_byte(8'hEF);
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(8'h53);
`endif
    expect_done();
    check("q_after_gap", 32'(exp_q.size()), 32'd0);

    // Zero length and oversize length
    do_reset();
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h00);
    expect_error();
    do_reset();
    send_byte(8'hA5);
    send_byte(8'h08);
    send_byte(8'h00);
    expect_error();

    // Full 1024-word image, last address all-ones
    do_reset();
    ws.delete();
    for (int i = 0; i < 1024; i++) ws.push_back(16'(i * 257) ^ 16'h5AC3);
    send_words(ws);
    expect_done();
    check("max_last_addr", 32'(oMemAddr), 32'h3FF);
    check("max_last_data", 32'(oMemData), 32'h5AC3 ^ 32'(16'(1023 * 257)));
    check("q_after_max", 32'(exp_q.size()), 32'd0);

    // Reset partway into the second word of a two-word frame
    do_reset();
    exp_q.push_back({10'h000, 16'h1122});
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    do_reset();
    ws = '{16'h55AA};
    send_words(ws);
    expect_done();
    check("q_after_abort", 32'(exp_q.size()), 32'd0);

`ifdef PROG_LOADER_CHECKSUM_EN
    // Explicit checksum pass and fail
    do_reset();
    exp_q.push_back({10'h000, 16'h1234});
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'hBA);
    check("chk_pass_done", 32'(oDone), 32'd1);
    check("chk_pass_cpureset", 32'(oCpuReset), 32'd0);
    do_reset();
    exp_q.push_back({10'h000, 16'h1234});
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'hBB);
    expect_error();
`endif

    idle_cycles(3);
    check("q_final_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Writer side of the instruction ROM interface: receives a byte stream from a host, assembles instruction words and writes them into program memory from address 0 upward.
- Holds the uP in reset until a complete, valid image is loaded, then releases it.
- Sits between the host byte source and the program-memory write port, and drives the uP reset input.

Parameters:
ADDR_WIDTH, 10, program-memory address width; max image = 2^ADDR_WIDTH words
INSN_WIDTH, 16, instruction word width; must be a multiple of 8 (BPW = INSN_WIDTH/8 bytes per word)
SYNC_BYTE, 8'hA5, frame start marker

Ports:
Clock  input  1  system clock, rising edge
Reset  input  1  synchronous, active-high reset
iByteData  input  8  incoming byte
iByteValid  input  1  iByteData valid
oByteReady  output  1  loader can accept a byte; transfer occurs when iByteValid && oByteReady at a rising edge
oMemWrEn  output  1  one-cycle write strobe to program memory
oMemAddr  output  ADDR_WIDTH  write address
oMemData  output  INSN_WIDTH  write data
oCpuReset  output  1  reset to the uP; high until load completes
oDone  output  1  image loaded successfully (sticky)
oError  output  1  frame error (sticky)

Behaviour:
- Clocking: single clock; Reset is synchronous and active-high; all state changes on the rising edge of Clock.
- Reset values: state IDLE, oMemWrEn 0, oMemAddr 0, oMemData 0, oCpuReset 1, oDone 0, oError 0, word/byte counters 0. oByteReady is 0 while Reset is high.
- Frame format: SYNC_BYTE, LEN_HI, LEN_LO (N = 16-bit word count), then N*BPW payload bytes, most significant byte of each word first.
- oByteReady is 1 in IDLE, LEN_HI, LEN_LO and DATA, and 0 in DONE and ERROR. It is decoded from state, so there is zero-latency acceptance.
- States and transitions:
  - IDLE: an accepted byte equal to SYNC_BYTE goes to LEN_HI; any other byte is discarded and the state stays IDLE.
  - LEN_HI: accept a byte, latch it as N[15:8], go to LEN_LO.
  - LEN_LO: accept a byte, latch it as N[7:0]. If N == 0 or N > 2^ADDR_WIDTH, go to ERROR; otherwise go to DATA.
  - DATA: shift each accepted byte into the word register. On the BPW-th byte of a word, on the next cycle oMemWrEn=1 for exactly one cycle with oMemData = assembled word and oMemAddr = current word index. The word index then increments, and the byte counter wraps to 0.
  - DATA exit: when the last byte of word N-1 is accepted at cycle k, go to DONE (or CHK if the optional feature is enabled). oMemWrEn pulses at k+1. At k+2, oDone=1 and oCpuReset=0.
  - DONE: terminal; oCpuReset stays 0 and input bytes are ignored. Only Reset exits.
  - ERROR: terminal; oError=1, oCpuReset stays 1, oDone stays 0. Only Reset exits.
- Back-to-back bytes: one byte per cycle is allowed. A write pulse may coincide with acceptance of the next word's bytes; this requires BPW >= 1, and the word register is double-buffered into oMemData.
- Address wrap: not possible, because N is bounded at LEN_LO. When N == 2^ADDR_WIDTH, the last address written is all-ones.
- Idle gaps (iByteValid low) in any state: no state change.
- Reset mid-load: abort and return to IDLE with reset values. Memory contents already written are left as-is; the uP remains held in reset.
- oMemAddr and oMemData hold their last values when oMemWrEn=0.

Optional Feature:
PROG_LOADER_CHECKSUM_EN
- With the macro: after DATA, enter state CHK and accept one more byte C. The loader keeps an 8-bit running sum S of all payload bytes.
  - If (S + C) mod 256 == 0: oDone=1 and oCpuReset=0 on the cycle after C is accepted.
  - Otherwise: ERROR, oCpuReset stays 1.
  - Memory writes still occur as data arrives.
- Without the macro: no CHK state and no sum register; DATA goes directly to DONE.

Test Plan:
- Reset, then send A5 00 02 12 34 AB CD at one byte per cycle -> oMemWrEn pulses with (addr 0, 0x1234) and (addr 1, 0xABCD); oDone=1 and oCpuReset=0 two cycles after the last byte is accepted.
- Send 00 FF A5 00 01 BE EF with iByteValid deasserted for 3 cycles between the 1st and 2nd payload bytes -> leading 00 and FF are discarded; a single write (addr 0, 0xBEEF); oDone=1.
- Send A5 00 00 -> oError=1, oByteReady=0, oCpuReset=1, and no oMemWrEn pulse. A5 08 00 with ADDR_WIDTH=10 (N=2048 > 1024) -> same response.
- Send A5 04 00 then 2048 payload bytes (ADDR_WIDTH=10) -> 1024 writes to addresses 0..1023, with the last address 0x3FF; oDone=1.
- Assert Reset for 1 cycle after 3 payload bytes of a 2-word frame, then send a full 1-word frame A5 00 01 55 AA -> write (addr 0, 0x55AA); no stale partial word is written; oDone=1.
- With PROG_LOADER_CHECKSUM_EN: A5 00 01 12 34 BA -> oDone=1, since 0x12+0x34+0xBA = 0x100. The same frame with checksum byte BB -> oError=1, oCpuReset=1.
